// File: rtl/lsu_mem_port_if.sv
// Bundles the pipeline request/response handshakes and the data_memory port of lsu_mem_port.
// The slave modport is the LSU's view; the master modport is the pipeline/memory environment.
interface lsu_mem_port_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] data_addr;
    logic [31:0] w_data_mem;
    logic        r_en_mem;
    logic        w_en_mem;
    logic [1:0]  byte_sel;
    logic [31:0] r_data_mem;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3,
        input  resp_ready, r_data_mem,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output data_addr, w_data_mem, r_en_mem, w_en_mem, byte_sel
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3,
        output resp_ready, r_data_mem,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  data_addr, w_data_mem, r_en_mem, w_en_mem, byte_sel
    );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store initiator between the MEM stage and data_memory: one request at a time,
// single-cycle memory access, extended and registered load response, error rejection.
module lsu_mem_port #(
    parameter int DROM_SPACE = 1024
) (
    input  logic           clk,
    input  logic           rst,
    lsu_mem_port_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [2:0]  req_size;
    logic [32:0] req_end;
    logic        req_err;
    logic [31:0] load_data;

    // The end address is formed in 33 bits so a request wrapping past 2^32 is out of range.
    always_comb begin
        case (bus.req_funct3[1:0])
            2'b00:   req_size = 3'd1;
            2'b01:   req_size = 3'd2;
            default: req_size = 3'd4;
        endcase
        req_end = {1'b0, bus.req_addr} + {30'd0, req_size};
        req_err = (bus.req_funct3 == 3'b011)
                | (bus.req_funct3[2:1] == 2'b11)
                | (bus.req_we & bus.req_funct3[2])
                | ((bus.req_funct3[1:0] == 2'b01) & bus.req_addr[0])
                | ((bus.req_funct3[1:0] == 2'b10) & (bus.req_addr[1:0] != 2'b00))
                | (req_end > 33'(DROM_SPACE));
    end

    always_comb begin
        case (funct3_q)
            3'b000:  load_data = {{24{bus.r_data_mem[7]}}, bus.r_data_mem[7:0]};
            3'b100:  load_data = {24'd0, bus.r_data_mem[7:0]};
            3'b001:  load_data = {{16{bus.r_data_mem[15]}}, bus.r_data_mem[15:0]};
            3'b101:  load_data = {16'd0, bus.r_data_mem[15:0]};
            default: load_data = bus.r_data_mem;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Memory-port outputs decode only from the state and the latched request.
    always_comb begin
        state_next     = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.data_addr  = 32'd0;
        bus.w_data_mem = 32'd0;
        bus.r_en_mem   = 1'b0;
        bus.w_en_mem   = 1'b0;
        bus.byte_sel   = 2'b00;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_next = req_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                bus.data_addr = addr_q;
                bus.byte_sel  = funct3_q[1:0];
                if (we_q) begin
                    bus.w_en_mem   = 1'b1;
                    bus.w_data_mem = wdata_q;
                end else begin
                    bus.r_en_mem = 1'b1;
                end
                state_next = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            funct3_q <= 3'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q     <= bus.req_we;
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata;
                        funct3_q <= bus.req_funct3;
                        rdata_q  <= 32'd0;
                        err_q    <= req_err;
                    end
                end
                ACCESS: begin
                    rdata_q <= we_q ? 32'd0 : load_data;
                    err_q   <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store initiator that sits between the pipeline MEM stage and `data_memory`. It accepts one load or store per request over a valid/ready handshake and drives the `data_memory` port for exactly one cycle. For loads it extracts and sign- or zero-extends the returned bytes, and it returns a registered response over a second valid/ready handshake. Misaligned, out-of-range and illegal requests are rejected with an error response and never reach memory.

## Interface
Parameters:
- `DROM_SPACE`, 1024: data memory size in bytes; must match `data_memory`.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `req_funct3` in 3: RISC-V funct3; 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts response.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: request rejected.
- `data_addr` out 32: to memory.
- `w_data_mem` out 32: to memory.
- `r_en_mem` out 1: to memory.
- `w_en_mem` out 1: to memory.
- `byte_sel` out 2: to memory; 00 byte, 01 half, 10 word.
- `r_data_mem` in 32: combinational read data from memory; byte at `data_addr` in [7:0].

## Operation
- States:
  - IDLE: `req_ready`=1.
  - ACCESS: memory port active.
  - RESP: `resp_valid`=1.
- IDLE, with `req_valid`=1:
  - Latch `req_we`, `req_addr`, `req_wdata`, `req_funct3`.
  - Evaluate errors. If any error: `resp_err`=1, `resp_rdata`=0, go to RESP. Otherwise go to ACCESS.
- Error conditions:
  - funct3 ∈ {011, 110, 111}.
  - Store with funct3 100 or 101.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]≠0.
  - addr + size > `DROM_SPACE`, where size is 1/2/4. Compute in 33 bits so wrap-around of `req_addr` near 2^32 counts as out of range.
- ACCESS (exactly one cycle):
  - Drive `data_addr` = latched addr and `byte_sel` from size.
  - Store: `w_en_mem`=1, `r_en_mem`=0, `w_data_mem` = latched wdata. Memory commits on the edge ending ACCESS.
  - Load: `r_en_mem`=1, `w_en_mem`=0, `w_data_mem`=0.
  - At the edge ending ACCESS, register the load result into `resp_rdata`:
    - B: sign-extend [7:0].
    - BU: zero-extend [7:0].
    - H: sign-extend [15:0].
    - HU: zero-extend [15:0].
    - W: [31:0].
  - Stores set `resp_rdata`=0. Set `resp_err`=0. Go to RESP.
- RESP: hold `resp_valid`, `resp_rdata` and `resp_err` stable until `resp_ready`=1, then go to IDLE.
- `r_en_mem` and `w_en_mem` are never both 1. Both are 0 outside ACCESS.
- Memory outputs (`data_addr`, `w_data_mem`, `byte_sel`) are 0 outside ACCESS.

## Timing
- Reset values: state IDLE; `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0; all memory outputs 0.
- Valid request accepted at edge N: ACCESS during cycle N+1, `resp_valid` from cycle N+2.
- Error request accepted at edge N: `resp_valid` from cycle N+1, with no memory cycle.
- Peak throughput is one request per 3 cycles, or per 2 for errors. `req_ready` is 0 in ACCESS and RESP; there is no request overlap.
- `resp_ready` held low stalls indefinitely in RESP with outputs stable; `req_ready` stays 0.
- `resp_ready` may be 1 before `resp_valid`; handshake completes on the first RESP cycle.
- Reset asserted mid-ACCESS: outputs clear immediately (async). A store may or may not have committed; the block issues no further memory activity and returns no response.
- All outputs are registered, or decoded from the registered state plus latched request; there is no combinational path from `req_*` to memory outputs.

## Test plan
- Store then load: SW addr 0x10, data 0xDEADBEEF. Expect `w_en_mem` for one cycle with `byte_sel`=10, then a response with err 0. A following LW at 0x10 returns `resp_rdata`=0xDEADBEEF exactly 2 cycles after acceptance.
- Byte extension: SB 0x80 to addr 0x21. Then LB 0x21 returns 0xFFFFFF80 and LBU 0x21 returns 0x00000080. SH 0x8001 at 0x22, then LH returns 0xFFFF8001 and LHU returns 0x00008001.
- Misalignment and illegal funct3: LH at 0x3, LW at 0x6, funct3=011, and SB-with-funct3 100. Each yields `resp_err`=1 and `resp_rdata`=0 one cycle after acceptance; `r_en_mem` and `w_en_mem` never assert.
- Bounds with DROM_SPACE=1024: LW 0x3FC succeeds. LW 0x3FD (misaligned) errors. LB 0x400 errors. LW 0xFFFFFFFC errors (wrap-around). LB 0x3FF succeeds.
- Backpressure: hold `resp_ready`=0 for 5 cycles after an LW. `resp_valid`/`resp_rdata` stay stable and `req_ready`=0 throughout; raising `resp_ready` returns the block to IDLE the next cycle.
- Reset: assert `rst`=0 during ACCESS of an SW. All outputs go to 0 and `req_ready` to 1 asynchronously. No response is issued; the next request after release behaves normally.
